note_pitch_detect: RTL and testbench

- Measures the period of an incoming square-wave tone (from an external oscillator or loopback of the buzzer drive) in system clocks.
- Classifies the period to the nearest note code: 0x01-0x07 low, 0x11-0x17 middle, 0x21-0x27 high, 0x31-0x37 super-high.
- Used for self-test of the music player and for note capture.

---
 rtl/note_pkg.sv | 47 ++++
 rtl/note_period_table.sv | 28 ++
 rtl/note_pitch_detect.sv | 200 ++++++++++++++++++++
 tb/tb_note_pitch_detect.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared constants for the note pitch detector: note codes, nominal note
// frequencies (ascending), the FSM state type and a small distance helper.
package note_pkg;

  localparam int NOTE_NUM = 28;

  localparam logic [7:0] NOTE_L1 = 8'h01, NOTE_L2 = 8'h02, NOTE_L3 = 8'h03,
                         NOTE_L4 = 8'h04, NOTE_L5 = 8'h05, NOTE_L6 = 8'h06,
                         NOTE_L7 = 8'h07;
  localparam logic [7:0] NOTE_M1 = 8'h11, NOTE_M2 = 8'h12, NOTE_M3 = 8'h13,
                         NOTE_M4 = 8'h14, NOTE_M5 = 8'h15, NOTE_M6 = 8'h16,
                         NOTE_M7 = 8'h17;
  localparam logic [7:0] NOTE_H1 = 8'h21, NOTE_H2 = 8'h22, NOTE_H3 = 8'h23,
                         NOTE_H4 = 8'h24, NOTE_H5 = 8'h25, NOTE_H6 = 8'h26,
                         NOTE_H7 = 8'h27;
  localparam logic [7:0] NOTE_S1 = 8'h31, NOTE_S2 = 8'h32, NOTE_S3 = 8'h33,
                         NOTE_S4 = 8'h34, NOTE_S5 = 8'h35, NOTE_S6 = 8'h36,
                         NOTE_S7 = 8'h37;

  localparam logic [7:0] NOTE_CODES [NOTE_NUM] = '{
    NOTE_L1, NOTE_L2, NOTE_L3, NOTE_L4, NOTE_L5, NOTE_L6, NOTE_L7,
    NOTE_M1, NOTE_M2, NOTE_M3, NOTE_M4, NOTE_M5, NOTE_M6, NOTE_M7,
    NOTE_H1, NOTE_H2, NOTE_H3, NOTE_H4, NOTE_H5, NOTE_H6, NOTE_H7,
    NOTE_S1, NOTE_S2, NOTE_S3, NOTE_S4, NOTE_S5, NOTE_S6, NOTE_S7
  };

  // Nominal frequencies in Hz, same order as NOTE_CODES (C4..B7 naturals).
  localparam int NOTE_FREQS [NOTE_NUM] = '{
     262,  294,  330,  349,  392,  440,  494,
     523,  587,  659,  698,  784,  880,  988,
    1047, 1175, 1319, 1397, 1568, 1760, 1976,
    2093, 2349, 2637, 2794, 3136, 3520, 3951
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_SEARCH  = 2'd2,
    ST_RESULT  = 2'd3
  } fsm_state_t;

  function automatic logic [19:0] abs_diff(input logic [19:0] a,
                                           input logic [19:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/note_period_table.sv
// Combinational note lookup: table index to note code and nominal period in
// system clocks (CLK_FRE / freq); indices past the table return zeros.
module note_period_table
  import note_pkg::*;
#(
  parameter int CLK_FRE = 50_000_000
) (
  input  logic [4:0]  index,
  output logic [7:0]  code,
  output logic [19:0] nominal
);

  logic [19:0] nom_rom [NOTE_NUM];

  for (genvar i = 0; i < NOTE_NUM; i++) begin : g_rom
    assign nom_rom[i] = 20'(CLK_FRE / NOTE_FREQS[i]);
  end

  always_comb begin
    code    = 8'h00;
    nominal = 20'd0;
    if (index < 5'(NOTE_NUM)) begin
      code    = NOTE_CODES[index];
      nominal = nom_rom[index];
    end
  end

endmodule

// File: rtl/note_pitch_detect.sv
// Measures the period of tone_in in system clocks and classifies it to the
// nearest note code. Define NOTE_PITCH_AVG_EN to classify 4-period averages.
//
// state   | meaning
// IDLE    | silent, first rising edge only restarts the period counter
// MEASURE | counting, next edge (or pending capture) starts a search
// SEARCH  | walks the 28-entry table, one index per clock
// RESULT  | outputs just updated, note_valid high for this clock
module note_pitch_detect
  import note_pkg::*;
#(
  parameter int CLK_FRE    = 50_000_000,
  parameter int TOL_SHIFT  = 5,
  parameter int MAX_PERIOD = CLK_FRE / 200,
  parameter int MIN_PERIOD = CLK_FRE / 4500,
  parameter int STABLE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [19:0] period,
  output logic [7:0]  note_code,
  output logic        note_valid,
  output logic        note_locked,
  output logic        silent
);

  localparam int              SW         = $clog2(STABLE_CNT + 1);
  localparam logic [19:0]     MAX_P      = 20'(MAX_PERIOD);
  localparam logic [19:0]     MIN_P      = 20'(MIN_PERIOD);
  localparam logic [4:0]      LAST_IDX   = 5'(NOTE_NUM - 1);
  localparam logic [SW-1:0]   STABLE_MAX = SW'(STABLE_CNT);

  fsm_state_t state, state_next;

  logic          tone_s1, tone_s2, tone_s3, edge_det;
  logic [19:0]   cnt, cnt_plus1, cap_reg, cap_now;
  logic [19:0]   search_in, search_val;
  logic          pending, take, search_start, timeout, last_step;
  logic [4:0]    idx;
  logic [7:0]    tbl_code, best_code, fin_code, new_code;
  logic [19:0]   tbl_nom, best_nom, fin_nom;
  logic [19:0]   diff, best_diff, fin_diff;
  logic          better;
  logic [SW-1:0] stable_cnt;

  // Synchronizer flops carry no reset so a reset with tone_in high does not
  // fabricate a rising edge on release.
  always_ff @(posedge clk) begin
    tone_s1 <= tone_in;
    tone_s2 <= tone_s1;
    tone_s3 <= tone_s2;
  end

  always_ff @(posedge clk) begin
    if (rst) edge_det <= 1'b0;
    else     edge_det <= tone_s2 & ~tone_s3;
  end

  assign cnt_plus1 = cnt + 20'd1;

  // A fresh edge in MEASURE beats a pending capture: the latest period wins.
  always_comb begin
    take    = 1'b0;
    cap_now = cap_reg;
    if (state == ST_MEASURE) begin
      if (edge_det) begin
        take    = 1'b1;
        cap_now = cnt_plus1;
      end else if (pending) begin
        take = 1'b1;
      end
    end
  end

  assign timeout = (state == ST_MEASURE) && !take && (cnt >= MAX_P);

`ifdef NOTE_PITCH_AVG_EN
  logic [21:0] acc, acc_sum;
  logic [1:0]  acc_cnt;

  assign acc_sum      = acc + 22'(cap_now);
  assign search_start = take && (acc_cnt == 2'd3);
  assign search_in    = 20'(acc_sum >> 2);

  always_ff @(posedge clk) begin
    if (rst || timeout) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (take) begin
      acc     <= (acc_cnt == 2'd3) ? 22'd0 : acc_sum;
      acc_cnt <= acc_cnt + 2'd1;
    end
  end
`else
  assign search_start = take;
  assign search_in    = cap_now;
`endif

  note_period_table #(
    .CLK_FRE (CLK_FRE)
  ) u_table (
    .index   (idx),
    .code    (tbl_code),
    .nominal (tbl_nom)
  );

  assign last_step = (state == ST_SEARCH) && (idx == LAST_IDX);
  assign diff      = abs_diff(search_val, tbl_nom);
  assign better    = diff < best_diff;
  assign fin_code  = better ? tbl_code : best_code;
  assign fin_nom   = better ? tbl_nom  : best_nom;
  assign fin_diff  = better ? diff     : best_diff;
  assign new_code  = ((search_val >= MIN_P) && (fin_diff <= (fin_nom >> TOL_SHIFT)))
                     ? fin_code : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (edge_det) state_next = ST_MEASURE;
      ST_MEASURE: begin
        if (search_start) state_next = ST_SEARCH;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_SEARCH:  if (last_step) state_next = ST_RESULT;
      ST_RESULT:  state_next = ST_MEASURE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    note_valid = (state == ST_RESULT);
  end

  assign note_locked = (stable_cnt == STABLE_MAX);

  // Outputs load on the last SEARCH clock so they appear together with
  // note_valid in RESULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      cap_reg    <= '0;
      pending    <= 1'b0;
      search_val <= '0;
      idx        <= '0;
      best_diff  <= '1;
      best_code  <= '0;
      best_nom   <= '0;
      period     <= '0;
      note_code  <= '0;
      stable_cnt <= '0;
      silent     <= 1'b1;
    end else begin
      if (edge_det)          cnt <= '0;
      else if (cnt < MAX_P)  cnt <= cnt_plus1;

      if (edge_det && (state == ST_SEARCH || state == ST_RESULT)) begin
        cap_reg <= cnt_plus1;
        pending <= 1'b1;
      end else if (take) begin
        pending <= 1'b0;
      end

      if (search_start) begin
        search_val <= search_in;
        idx        <= '0;
        best_diff  <= '1;
        best_code  <= '0;
        best_nom   <= '0;
      end else if (state == ST_SEARCH) begin
        idx <= idx + 5'd1;
        if (better) begin
          best_diff <= diff;
          best_code <= tbl_code;
          best_nom  <= tbl_nom;
        end
      end

      if (last_step) begin
        period    <= search_val;
        note_code <= new_code;
        silent    <= 1'b0;
        if (new_code == 8'h00)           stable_cnt <= '0;
        else if (new_code == note_code) begin
          if (stable_cnt != STABLE_MAX)  stable_cnt <= stable_cnt + 1'b1;
        end else                         stable_cnt <= SW'(1);
      end else if (timeout) begin
        note_code  <= '0;
        stable_cnt <= '0;
        silent     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_note_pitch_detect.sv
// Directed bench for note_pitch_detect, run with CLK_FRE scaled to 500 kHz so
// nominal periods are 1/100 of the 50 MHz values (440 Hz -> 1136 clocks).
module tb_note_pitch_detect;

  localparam int CLK_FRE = 500_000;  // MAX_PERIOD 2500, MIN_PERIOD 111

  logic        clk = 1'b0;
  logic        rst;
  logic        tone_in;
  logic [19:0] period;
  logic [7:0]  note_code;
  logic        note_valid;
  logic        note_locked;
  logic        silent;

  note_pitch_detect #(.CLK_FRE(CLK_FRE)) dut (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .period      (period),
    .note_code   (note_code),
    .note_valid  (note_valid),
    .note_locked (note_locked),
    .silent      (silent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  int ev_code[$];
  int ev_period[$];
  int ev_locked[$];
  int ev_lat[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, sampled on the falling edge; logs every note_valid pulse.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (note_valid) begin
      ev_code.push_back(int'(note_code));
      ev_period.push_back(int'(period));
      ev_locked.push_back(int'(note_locked));
      ev_lat.push_back(cyc - last_rise);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic one_period(input int p);
    tone_in   = 1'b1;
    last_rise = cyc;
    steps(p / 2);
    tone_in = 1'b0;
    steps(p - p / 2);
  endtask

  task automatic tone(input int p, input int n);
    repeat (n) one_period(p);
  endtask

  task automatic clear_ev();
    ev_code.delete();
    ev_period.delete();
    ev_locked.delete();
    ev_lat.delete();
  endtask

  initial begin
    rst     = 1'b1;
    tone_in = 1'b0;
    steps(5);
    check("rst_period", int'(period), 0);
    check("rst_code", int'(note_code), 0);
    check("rst_valid", int'(note_valid), 0);
    check("rst_locked", int'(note_locked), 0);
    check("rst_silent", int'(silent), 1);
    rst = 1'b0;
    steps(10);
    check("idle_silent", int'(silent), 1);

    // 440 Hz: first edge only restarts, 3 classifications, lock on the 3rd
    clear_ev();
    tone(1136, 4);
    check("a4_count", ev_code.size(), 3);
    check("a4_code", ev_code[0], 'h06);
    check("a4_period", ev_period[0], 1136);
    check("a4_latency", ev_lat[0], 32);
    check("a4_lock1", ev_locked[1], 0);
    check("a4_lock2", ev_locked[2], 1);
    check("a4_silent", int'(silent), 0);

    // 3951 Hz: first capture is still the last 440 Hz period
    clear_ev();
    tone(126, 5);
    check("b7_count", ev_code.size(), 5);
    check("b7_prev_code", ev_code[0], 'h06);
    check("b7_prev_lock", ev_locked[0], 1);
    check("b7_code", ev_code[1], 'h37);
    check("b7_period", ev_period[1], 126);
    check("b7_lock_drop", ev_locked[1], 0);
    check("b7_lock_re", ev_locked[3], 1);

    // switch to 2093 Hz: lock drops, then reasserts after 3 periods
    clear_ev();
    tone(238, 4);
    check("c7_count", ev_code.size(), 4);
    check("c7_prev_code", ev_code[0], 'h37);
    check("c7_code", ev_code[1], 'h31);
    check("c7_lock_drop", ev_locked[1], 0);
    check("c7_lock_mid", ev_locked[2], 0);
    check("c7_lock_re", ev_locked[3], 1);
    check("c7_code3", ev_code[3], 'h31);

    // 415 Hz: outside tolerance of both neighbours
    clear_ev();
    tone(1205, 3);
    check("off_count", ev_code.size(), 3);
    check("off_prev_code", ev_code[0], 'h31);
    check("off_code", ev_code[1], 0);
    check("off_period", ev_period[1], 1205);
    check("off_lock", ev_locked[2], 0);

    // 440 Hz for 5 periods, then silence; timeout 2505 clocks after last rise
    clear_ev();
    tone(1136, 5);
    check("stop_count", ev_code.size(), 5);
    check("stop_lock", ev_locked[4], 1);
    steps(1264);
    check("stop_silent_early", int'(silent), 0);
    check("stop_code_early", int'(note_code), 'h06);
    steps(104);
    check("stop_silent_edge", int'(silent), 0);
    step();
    check("stop_silent", int'(silent), 1);
    check("stop_code", int'(note_code), 0);
    check("stop_locked", int'(note_locked), 0);
    check("stop_period_kept", int'(period), 1136);
    steps(95);
    check("stop_no_valid", ev_code.size(), 5);

    // 10 kHz glitches from IDLE: below MIN_PERIOD
    clear_ev();
    tone(50, 4);
    check("gl_count", ev_code.size(), 3);
    check("gl_code0", ev_code[0], 0);
    check("gl_code2", ev_code[2], 0);
    check("gl_period", ev_period[2], 50);
    check("gl_latency", ev_lat[0], 32);
    check("gl_silent", int'(silent), 0);

    // 523 Hz, then reset in the middle of a search
    clear_ev();
    tone(956, 2);
    check("c5_code", ev_code[1], 'h11);
    clear_ev();
    tone_in   = 1'b1;
    last_rise = cyc;
    steps(13);
    rst = 1'b1;
    step();
    check("mid_rst_period", int'(period), 0);
    check("mid_rst_code", int'(note_code), 0);
    check("mid_rst_valid", int'(note_valid), 0);
    check("mid_rst_locked", int'(note_locked), 0);
    check("mid_rst_silent", int'(silent), 1);
    rst = 1'b0;
    steps(478 - 14);
    tone_in = 1'b0;
    steps(478);
    check("mid_rst_no_valid", ev_code.size(), 0);
    tone(956, 2);
    check("post_rst_count", ev_code.size(), 1);
    check("post_rst_code", ev_code[0], 'h11);
    check("post_rst_period", ev_period[0], 956);
    check("post_rst_locked", ev_locked[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
